// File: rtl/rps_rgb_arbiter.sv
// N-channel debounced button race: first channel to reach its press
// threshold locks and drives its colour on the registered RGB outputs.
module rps_rgb_arbiter #(
    parameter int                     N_CH        = 3,
    parameter int                     DEB_CYCLES  = 1000,
    parameter int                     CNT_W       = 4,
    parameter logic [N_CH*CNT_W-1:0]  THRESH      = {4'd1, 4'd1, 4'd3},
    parameter logic [N_CH*3-1:0]      COLOUR      = {3'b110, 3'b101, 3'b011},
    parameter logic [2:0]             IDLE_RGB    = 3'b000,
    parameter int                     HOLD_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_n,
    input  logic            clr,
    output logic            led_r,
    output logic            led_g,
    output logic            led_b,
    output logic            win_valid,
    output logic [2:0]      win_idx
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    logic [N_CH-1:0]  r_s1;
    logic [N_CH-1:0]  r_s2;
    logic [N_CH-1:0]  r_stable;
    logic [N_CH-1:0]  r_stab_d;
    logic [N_CH-1:0]  r_press;
    logic [DW-1:0]    r_deb [N_CH];

    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [HW-1:0]    r_hold;
    state_t           r_state;
    logic [2:0]       r_rgb;
    logic             r_valid;
    logic [2:0]       r_idx;

    logic [CNT_W-1:0] w_thr [N_CH];
    logic [2:0]       w_col [N_CH];
    logic [N_CH-1:0]  w_hit;
    logic             w_any;
    logic [2:0]       w_sel;
    logic [2:0]       w_sel_rgb;

    for (genvar g = 0; g < N_CH; g++) begin : g_tab
        assign w_thr[g] = THRESH[g*CNT_W +: CNT_W];
        assign w_col[g] = COLOUR[g*3 +: 3];
        assign w_hit[g] = r_press[g] &&
            (({1'b0, r_cnt[g]} + (CNT_W+1)'(1)) >= {1'b0, w_thr[g]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= btn_n;
            r_s2 <= r_s1;
        end
    end

    // Stable level flips only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '1;
            r_stab_d <= '1;
            r_press  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_deb[i] <= '0;
            end
        end else begin
            r_stab_d <= r_stable;
            r_press  <= r_stab_d & ~r_stable;
            for (int i = 0; i < N_CH; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_deb[i] <= '0;
                end else if (r_deb[i] == DEB_LAST) begin
                    r_stable[i] <= r_s2[i];
                    r_deb[i]    <= '0;
                end else begin
                    r_deb[i] <= r_deb[i] + DW'(1);
                end
            end
        end
    end

    // Later (higher) indices override, so the highest qualifying channel wins
    always_comb begin
        w_any     = 1'b0;
        w_sel     = '0;
        w_sel_rgb = IDLE_RGB;
        for (int i = 0; i < N_CH; i++) begin
            if (w_hit[i]) begin
                w_any     = 1'b1;
                w_sel     = 3'(i);
                w_sel_rgb = w_col[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rgb   <= IDLE_RGB;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_hold  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (clr) begin
            r_state <= S_IDLE;
            r_rgb   <= IDLE_RGB;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_hold  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (r_press[i] && (r_cnt[i] < w_thr[i])) begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    if (w_any) begin
                        r_state <= S_LOCKED;
                        r_rgb   <= w_sel_rgb;
                        r_valid <= 1'b1;
                        r_idx   <= w_sel;
                        r_hold  <= '0;
                    end
                end
                S_LOCKED: begin
                    if (HOLD_CYCLES > 0) begin
                        if (r_hold == HOLD_LAST) begin
                            r_state <= S_IDLE;
                            r_rgb   <= IDLE_RGB;
                            r_valid <= 1'b0;
                            r_idx   <= '0;
                            r_hold  <= '0;
                            for (int i = 0; i < N_CH; i++) begin
                                r_cnt[i] <= '0;
                            end
                        end else begin
                            r_hold <= r_hold + HW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign led_r     = r_rgb[2];
    assign led_g     = r_rgb[1];
    assign led_b     = r_rgb[0];
    assign win_valid = r_valid;
    assign win_idx   = r_idx;

endmodule

// File: tb/tb_rps_rgb_arbiter.sv
// Scoreboard bench for rps_rgb_arbiter: hold-until-clear and auto-release
// instances share stimulus; a reference model predicts each output change.
module tb_rps_rgb_arbiter;

    localparam int DEB = 4;

    typedef struct {
        int         e;
        logic [6:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] btn_n = 3'b111;

    logic       r0, g0, b0, v0;
    logic [2:0] i0;
    logic       r1, g1, b1, v1;
    logic [2:0] i1;
    logic [6:0] o0, o1;

    assign o0 = {r0, g0, b0, v0, i0};
    assign o1 = {r1, g1, b1, v1, i1};

    rps_rgb_arbiter #(.DEB_CYCLES(DEB)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .clr(clr),
        .led_r(r0), .led_g(g0), .led_b(b0),
        .win_valid(v0), .win_idx(i0)
    );

    rps_rgb_arbiter #(.DEB_CYCLES(DEB), .HOLD_CYCLES(10)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .clr(clr),
        .led_r(r1), .led_g(g1), .led_b(b1),
        .win_valid(v1), .win_idx(i1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state
    int         thr [3];
    logic [2:0] col [3];
    int         hold [2];
    logic [2:0] mst, prv;
    int         since [3];
    logic [2:0] pl0, pl1, pl2, pl3;
    int         cnt [2][3];
    bit         locked [2];
    int         lock_e [2];
    logic [6:0] cur [2];

    task automatic chk(input string nm, input logic [6:0] got,
                       input logic [6:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (edge %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mst = '1;
        prv = '1;
        pl0 = '0; pl1 = '0; pl2 = '0; pl3 = '0;
        for (int i = 0; i < 3; i++) since[i] = 0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 3; i++) cnt[m][i] = 0;
            locked[m] = 0;
            lock_e[m] = 0;
            cur[m] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic game(input int m, input int e, input logic [2:0] eff,
                        input logic c);
        int w;
        logic [6:0] nv;
        exp_t x;
        nv = cur[m];
        if (c) begin
            for (int i = 0; i < 3; i++) cnt[m][i] = 0;
            locked[m] = 0;
            nv = '0;
        end else if (locked[m]) begin
            if (hold[m] > 0 && e == lock_e[m] + hold[m]) begin
                for (int i = 0; i < 3; i++) cnt[m][i] = 0;
                locked[m] = 0;
                nv = '0;
            end
        end else begin
            w = -1;
            for (int i = 0; i < 3; i++) begin
                if (eff[i]) begin
                    if (cnt[m][i] < thr[i]) cnt[m][i]++;
                    if (cnt[m][i] >= thr[i]) w = i;
                end
            end
            if (w >= 0) begin
                locked[m] = 1;
                lock_e[m] = e;
                nv = {col[w], 1'b1, 3'(w)};
            end
        end
        if (nv != cur[m]) begin
            x.e = e;
            x.v = nv;
            if (m == 0) q0.push_back(x);
            else q1.push_back(x);
            cur[m] = nv;
        end
    endtask

    // A press is a button held low for DEB consecutive samples; its
    // effect reaches the outputs four edges after the last such sample.
    task automatic model_edge(input int e, input logic [2:0] b,
                              input logic c);
        logic [2:0] np;
        logic [2:0] eff;
        np = '0;
        for (int i = 0; i < 3; i++) begin
            if (b[i] != prv[i]) since[i] = e;
            prv[i] = b[i];
            if (b[i] != mst[i] && (e - since[i] + 1) >= DEB) begin
                mst[i] = b[i];
                if (!b[i]) np[i] = 1'b1;
            end
        end
        eff = pl3;
        pl3 = pl2;
        pl2 = pl1;
        pl1 = pl0;
        pl0 = np;
        game(0, e, eff, c);
        game(1, e, eff, c);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            if (!rst_n) model_reset();
            else model_edge(cyc + 1, btn_n, clr);
            @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic press(input int ch, input int lo, input int hi);
        btn_n[ch] = 1'b0;
        tick(lo);
        btn_n[ch] = 1'b1;
        tick(hi);
    endtask

    task automatic mon_one(input int m, input logic [6:0] o,
                           input logic [6:0] p);
        exp_t x;
        bit have;
        have = 0;
        if (m == 0 && q0.size() > 0 && q0[0].e <= cyc) begin
            x = q0.pop_front();
            have = 1;
        end
        if (m == 1 && q1.size() > 0 && q1[0].e <= cyc) begin
            x = q1.pop_front();
            have = 1;
        end
        if (have) begin
            n_chk++;
            if (x.e != cyc || o !== x.v) begin
                n_fail++;
                $display("FAIL sb%0d edge %0d: got %b expected %b due %0d",
                         m, cyc, o, x.v, x.e);
            end
        end else if (o !== p) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb%0d edge %0d: unexpected change %b -> %b",
                     m, cyc, p, o);
        end
    endtask

    initial begin
        logic [6:0] p0;
        logic [6:0] p1;
        p0 = '0;
        p1 = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon_one(0, o0, p0);
                mon_one(1, o1, p1);
            end
            p0 = o0;
            p1 = o1;
        end
    end

    initial begin
        int n;
        int tmr [3];
        thr[0] = 3; thr[1] = 1; thr[2] = 1;
        col[0] = 3'b011; col[1] = 3'b101; col[2] = 3'b110;
        hold[0] = 0; hold[1] = 10;
        model_reset();

        @(negedge clk);
        tick(3);
        chk("reset d0", o0, 7'd0);
        chk("reset d1", o1, 7'd0);
        rst_n = 1'b1;
        tick(6);

        // single press on channel 2, exact latency
        btn_n[2] = 1'b0;
        tick(7);
        chk("ch2 before latency", o0, 7'd0);
        tick(1);
        chk("ch2 win d0", o0, 7'b110_1_010);
        chk("ch2 win d1", o1, 7'b110_1_010);
        btn_n[0] = 1'b0;
        btn_n[1] = 1'b0;
        tick(10);
        chk("locked ignores", o0, 7'b110_1_010);
        btn_n = 3'b111;
        tick(10);
        pulse_clr();
        chk("clr d0", o0, 7'd0);
        chk("clr d1", o1, 7'd0);
        tick(4);

        // channel 0 needs three presses
        press(0, 8, 8);
        press(0, 8, 8);
        chk("ch0 two presses", o0, 7'd0);
        press(0, 8, 8);
        chk("ch0 third press", o0, 7'b011_1_000);
        pulse_clr();
        tick(4);

        // bouncing channel 1, then a clean hold
        for (int k = 0; k < 5; k++) begin
            btn_n[1] = 1'b0;
            tick(2);
            btn_n[1] = 1'b1;
            tick(2);
        end
        chk("bounce no press", o0, 7'd0);
        btn_n[1] = 1'b0;
        tick(7);
        chk("bounce before latency", o0, 7'd0);
        tick(1);
        chk("bounce win", o0, 7'b101_1_001);
        btn_n[1] = 1'b1;
        tick(10);
        pulse_clr();
        tick(4);

        // simultaneous channels 1 and 2
        btn_n[1] = 1'b0;
        btn_n[2] = 1'b0;
        tick(8);
        chk("tie highest", o0, 7'b110_1_010);
        btn_n = 3'b111;
        tick(10);
        pulse_clr();
        tick(4);

        // clr on the same edge as a qualifying press
        btn_n[2] = 1'b0;
        tick(7);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(3);
        chk("clr beats press d0", o0, 7'd0);
        chk("clr beats press d1", o1, 7'd0);
        btn_n[2] = 1'b1;
        tick(10);

        // auto-release after the hold time
        btn_n[1] = 1'b0;
        n = 0;
        while (!v1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("hold win", o1, 7'b101_1_001);
        n = 0;
        while (v1 && n < 30) begin
            n++;
            tick(1);
        end
        n_chk++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL hold length: got %0d cycles expected 10", n);
        end
        btn_n[1] = 1'b1;
        tick(10);
        pulse_clr();
        tick(4);

        // async reset mid-lock, button held through reset
        btn_n[2] = 1'b0;
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("async rst d0", o0, 7'd0);
        chk("async rst d1", o1, 7'd0);
        tick(3);
        rst_n = 1'b1;
        tick(12);
        chk("held through reset", o0, 7'b110_1_010);
        btn_n[2] = 1'b1;
        tick(10);
        pulse_clr();
        tick(4);

        // randomized phase
        for (int i = 0; i < 3; i++) tmr[i] = $urandom_range(1, 12);
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 3; i++) begin
                tmr[i]--;
                if (tmr[i] <= 0) begin
                    btn_n[i] = ~btn_n[i];
                    tmr[i] = ($urandom_range(0, 4) == 0) ?
                             $urandom_range(10, 25) : $urandom_range(1, 9);
                end
            end
            clr = ($urandom_range(0, 59) == 0);
            tick(1);
        end
        clr = 1'b0;
        btn_n = 3'b111;
        tick(20);
        pulse_clr();
        tick(5);

        n_chk++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL sb0 drain: %0d left expected 0", q0.size());
        end
        n_chk++;
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL sb1 drain: %0d left expected 0", q1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
